// File: rtl/uart_char_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_char_rx
// Purpose  : 8N1 UART receiver with a first-word-fall-through character FIFO.
//            Feeds the UCI command parser through a valid/ready byte stream.
//            Carriage returns can be dropped so downstream sees LF-only lines.
// Revision : 1.0 - initial release
// ============================================================================
module uart_char_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STRIP_CR   = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rx_in,
    output logic [7:0]                    char_out,
    output logic                          char_out_valid,
    input  logic                          char_out_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_bit_cycles  = CLK_HZ / BAUD;
    localparam int c_half_cycles = c_bit_cycles / 2;
    localparam int c_cnt_w       = $clog2(c_bit_cycles) + 1;
    localparam int c_ptr_w       = $clog2(FIFO_DEPTH);
    localparam int c_count_w     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_cnt_w-1:0]   c_bit_last  = c_cnt_w'(c_bit_cycles - 1);
    localparam logic [c_cnt_w-1:0]   c_half_last = c_cnt_w'(c_half_cycles - 1);
    localparam logic [c_count_w-1:0] c_depth     = c_count_w'(FIFO_DEPTH);
    localparam logic [7:0]           c_cr        = 8'h0D;
    localparam logic                 c_strip     = (STRIP_CR != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser
    logic                   r_rx_meta;
    logic                   r_rx_s;

    // Receive FSM
    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_frame_err;

    // FIFO
    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_count_w-1:0]   r_count;
    logic                   r_overflow;

    logic                   w_cnt_half;
    logic                   w_cnt_bit;
    logic                   w_stop_done;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_accept;

    assign w_cnt_half  = (r_cnt == c_half_last);
    assign w_cnt_bit   = (r_cnt == c_bit_last);

    // The stop bit is sampled on the last cycle of STOP; a good byte is
    // offered to the FIFO on that very cycle, so a CR is filtered here.
    assign w_stop_done = (r_state == S_STOP) && w_cnt_bit;
    assign w_push      = w_stop_done && r_rx_s && !(c_strip && (r_shift == c_cr));

    assign w_full      = (r_count == c_depth);
    assign w_pop       = (r_count != '0) && char_out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_accept    = w_push && (!w_full || w_pop);

    assign char_out       = r_mem[r_rd_ptr];
    assign char_out_valid = (r_count != '0);
    assign fifo_count     = r_count;
    assign frame_err      = r_frame_err;
    assign overflow       = r_overflow;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame receiver: start validation, LSB-first data sampling, stop check
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_cnt_half) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A line back high by mid start bit was only a glitch.
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_bit) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_bit) begin
                        r_cnt       <= '0;
                        r_frame_err <= !r_rx_s;
                        // Leave mid stop bit so a back-to-back start is caught.
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Character FIFO: write on accepted push, advance head on handshake
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_accept) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_char_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_char_rx
// Purpose  : Scoreboard bench for uart_char_rx. Two instances share the serial
//            line and ready: one strips CR, one keeps it. A queue per instance
//            holds the characters the line should deliver; monitors pop and
//            compare on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_char_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 62_500;
    localparam int DEPTH  = 16;
    localparam int BITC   = CLK_HZ / BAUD;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       rx_in  = 1'b1;
    logic       char_out_ready = 1'b0;

    logic [7:0] char_out_a, char_out_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       ovf_a, ovf_b;
    logic [4:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int exp_ferr = 0, seen_ferr = 0;
    int exp_ovf_a = 0, seen_ovf_a = 0;
    int exp_ovf_b = 0, seen_ovf_b = 0;
    int max_count_a = 0;
    int ready_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random

    uart_char_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .STRIP_CR(1)) dut_strip (
        .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in),
        .char_out(char_out_a), .char_out_valid(valid_a), .char_out_ready(char_out_ready),
        .frame_err(ferr_a), .overflow(ovf_a), .fifo_count(count_a)
    );

    uart_char_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .STRIP_CR(0)) dut_keep (
        .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in),
        .char_out(char_out_b), .char_out_valid(valid_b), .char_out_ready(char_out_ready),
        .frame_err(ferr_b), .overflow(ovf_b), .fifo_count(count_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Consumer ready driver
    initial forever begin
        @(posedge clk_in);
        #1;
        case (ready_mode)
            0:       char_out_ready = 1'b0;
            1:       char_out_ready = 1'b1;
            default: char_out_ready = 1'($urandom % 2);
        endcase
    end

    // Monitor: pop expected characters on each handshake, count pulses
    initial forever begin
        logic [7:0] e;
        @(negedge clk_in);
        if (ferr_a) seen_ferr++;
        if (ovf_a)  seen_ovf_a++;
        if (ovf_b)  seen_ovf_b++;
        if (int'(count_a) > max_count_a) max_count_a = int'(count_a);
        if (valid_a && char_out_ready) begin
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL strip_stream: got unexpected 0x%0h, required nothing", char_out_a);
            end else begin
                e = exp_a.pop_front();
                check("strip_stream", 32'(char_out_a), 32'(e));
            end
        end
        if (valid_b && char_out_ready) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL keep_stream: got unexpected 0x%0h, required nothing", char_out_b);
            end else begin
                e = exp_b.pop_front();
                check("keep_stream", 32'(char_out_b), 32'(e));
            end
        end
    end

    // Reference model: what the line should deliver for one frame
    task automatic model_frame(input logic [7:0] d, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else begin
            if (d != 8'h0D) begin
                if (ready_mode == 0 && exp_a.size() >= DEPTH) exp_ovf_a++;
                else exp_a.push_back(d);
            end
            if (ready_mode == 0 && exp_b.size() >= DEPTH) exp_ovf_b++;
            else exp_b.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap_bits);
        model_frame(d, stop_ok);
        rx_in = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick(BITC);
        end
        rx_in = stop_ok;
        tick(BITC);
        rx_in = 1'b1;
        tick(gap_bits * BITC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] d;
        bit ok;

        // Reset state
        tick(3);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_char",  32'(char_out_a), 0);
        check("rst_ferr",  32'(ferr_a), 0);
        check("rst_ovf",   32'(ovf_a), 0);
        rst_in = 1'b1;
        tick(3);

        // Single byte, latency from the start edge and handshake
        ready_mode = 0;
        tick(2);
        lat = -1;
        fork
            send_frame(8'h67, 1'b1, 1);
            begin
                for (int c = 1; c <= 400; c++) begin
                    @(posedge clk_in);
                    #1;
                    if (valid_a) begin
                        lat = c;
                        break;
                    end
                end
            end
        join
        check("t1_latency_window", 32'(lat >= 150 && lat <= 160), 1);
        check("t1_char", 32'(char_out_a), 32'h67);
        check("t1_count", 32'(count_a), 1);
        ready_mode = 1;
        tick(4);
        check("t1_count_after_pop", 32'(count_a), 0);
        check("t1_drained_a", 32'(exp_a.size()), 0);
        check("t1_drained_b", 32'(exp_b.size()), 0);

        // "go\r\n" back to back with ready high
        max_count_a = 0;
        send_frame(8'h67, 1'b1, 0);
        send_frame(8'h6F, 1'b1, 0);
        send_frame(8'h0D, 1'b1, 0);
        send_frame(8'h0A, 1'b1, 1);
        tick(4);
        check("t2_max_count", 32'(max_count_a <= 1), 1);
        check("t2_drained_a", 32'(exp_a.size()), 0);
        check("t2_drained_b", 32'(exp_b.size()), 0);

        // Bad stop bit then a good frame
        send_frame(8'h41, 1'b0, 2);
        check("t3_frame_err", 32'(seen_ferr), 32'(exp_ferr));
        check("t3_no_valid", 32'(valid_a), 0);
        send_frame(8'h42, 1'b1, 1);
        tick(4);
        check("t3_drained_a", 32'(exp_a.size()), 0);

        // Short low glitch
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(3 * BITC);
        check("t4_frame_err", 32'(seen_ferr), 32'(exp_ferr));
        check("t4_count", 32'(count_a), 0);

        // Fill past capacity with ready low, then drain
        ready_mode = 0;
        tick(2);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 0);
        tick(4);
        check("t5_count_a", 32'(count_a), 16);
        check("t5_count_b", 32'(count_b), 16);
        check("t5_ovf_a", 32'(seen_ovf_a), 32'(exp_ovf_a));
        check("t5_ovf_b", 32'(seen_ovf_b), 32'(exp_ovf_b));
        ready_mode = 1;
        tick(40);
        check("t5_drained_a", 32'(exp_a.size()), 0);
        check("t5_drained_b", 32'(exp_b.size()), 0);
        check("t5_count_after", 32'(count_b), 0);

        // Reset in the middle of a frame with bytes queued
        ready_mode = 0;
        tick(2);
        send_frame(8'h31, 1'b1, 0);
        send_frame(8'h32, 1'b1, 0);
        send_frame(8'h33, 1'b1, 0);
        tick(2);
        check("t6_count_before", 32'(count_a), 3);
        d = 8'h5A;
        rx_in = 1'b0;
        tick(BITC);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            tick(BITC);
        end
        tick(5);
        rst_in = 1'b0;
        #1;
        check("t6_valid", 32'(valid_a), 0);
        check("t6_count_a", 32'(count_a), 0);
        check("t6_count_b", 32'(count_b), 0);
        check("t6_char", 32'(char_out_a), 0);
        check("t6_ferr_ovf", 32'({ferr_a, ovf_a}), 0);
        exp_a.delete();
        exp_b.delete();
        rx_in = 1'b1;
        tick(3);
        rst_in = 1'b1;
        tick(3);
        send_frame(8'h75, 1'b1, 1);
        check("t6_count_after", 32'(count_a), 1);
        check("t6_char_after", 32'(char_out_a), 32'h75);
        ready_mode = 1;
        tick(4);
        check("t6_drained_a", 32'(exp_a.size()), 0);

        // Randomised traffic with a randomly stalling consumer
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom);
            if ($urandom % 6 == 0) d = 8'h0D;
            ok = ($urandom % 8) != 0;
            send_frame(d, ok, ok ? int'($urandom_range(0, 1)) : 2);
        end
        ready_mode = 1;
        tick(40);
        check("rnd_drained_a", 32'(exp_a.size()), 0);
        check("rnd_drained_b", 32'(exp_b.size()), 0);
        check("rnd_frame_err", 32'(seen_ferr), 32'(exp_ferr));
        check("rnd_ovf_a", 32'(seen_ovf_a), 32'(exp_ovf_a));
        check("rnd_ovf_b", 32'(seen_ovf_b), 32'(exp_ovf_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_char_rx.md
Name: uart_char_rx

Overview:
Serial receive front-end that feeds the UCI command parser. It deserialises 8N1 UART bytes from the host and buffers them in a small FIFO. Characters are presented on a valid/ready byte stream that connects directly to the parser's character input. Carriage returns are optionally stripped so the downstream block sees LF-terminated commands only.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD, 115200, serial bit rate
FIFO_DEPTH, 16, character buffer entries; power of two, >=2
STRIP_CR, 1, when 1, received 0x0D bytes are discarded and never enqueued

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rx_in  input  1  raw UART line; idle high; asynchronous to clk_in
char_out  output  8  head-of-FIFO character
char_out_valid  output  1  FIFO non-empty
char_out_ready  input  1  consumer accepts char_out this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: byte dropped because FIFO full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_in low, async assert, released synchronously via clock edge): synchroniser flops = 1, FSM = IDLE, FIFO empty, char_out=0, char_out_valid=0, frame_err=0, overflow=0, fifo_count=0. Reset mid-frame discards the partial byte and all buffered bytes.
- rx_in passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- BIT = CLK_HZ/BAUD (integer, truncated); HALF = BIT/2. Bit counter width is $clog2(BIT)+1.
- FSM:
  - IDLE: rx_s==0 -> START, counter cleared.
  - START: at counter==HALF-1, sample rx_s. If 0 -> DATA with counter and bit index cleared. If 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: every BIT cycles, sample rx_s into the shift register, LSB first. After the 8th sample -> STOP.
  - STOP: after BIT cycles, sample rx_s (mid stop bit). Then -> IDLE in the same cycle, so back-to-back frames are received.
    - Sample 1: byte complete. Enqueue it unless STRIP_CR && byte==0x0D.
    - Sample 0: frame_err=1 for one cycle; byte discarded.
- FIFO is first-word-fall-through:
  - char_out_valid = (count!=0); char_out = mem[rd_ptr].
  - Pop occurs when char_out_valid && char_out_ready.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Push latency: a byte enqueued on cycle N into an empty FIFO shows char_out_valid=1 on cycle N+1.
- Simultaneous push and pop: both take effect; count unchanged. When full, a push with a same-cycle pop is accepted.
- Full and push without pop: byte dropped, overflow=1 for one cycle, FIFO contents unchanged.
- Pop when empty: impossible, since valid is low; ready is ignored.
- char_out_ready has no effect on the receive FSM. Reception never stalls.

Test Plan:
1. CLK_HZ=1_000_000, BAUD=62_500 (BIT=16): send 0x67 -> char_out=0x67 with char_out_valid=1 one cycle after the stop-bit sample (~154 cycles after the falling edge); fifo_count=1; drops to 0 on the ready handshake.
2. STRIP_CR=1, ready held high: send "go\r\n" back-to-back -> stream exactly 0x67, 0x6F, 0x0A in order, with no 0x0D; fifo_count never exceeds 1. Repeat with STRIP_CR=0 -> four bytes including 0x0D.
3. Send 0x41 with the stop bit driven low -> one frame_err pulse, char_out_valid stays 0. The following correct frame 0x42 is received normally.
4. Low glitch of 4 cycles on rx_in -> FSM returns to IDLE, no output, no frame_err.
5. char_out_ready=0, send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> fifo_count=16, one overflow pulse on the 17th byte. Then assert ready -> 0x00..0x0F drain in order and 0x10 never appears.
6. Assert rst_in low mid-DATA of a byte while 3 bytes are queued -> all outputs reach reset values immediately. After release, a full frame 0x75 is received correctly with fifo_count=1.
